// File: rtl/iter_div.sv
// Iterative 32-bit restoring divider, signed/unsigned, one quotient bit per cycle.
// Optional macro ITER_DIV_EARLY_OUT_EN: short path for zero divisor or |divisor| > |dividend|.
module iter_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        Sign,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;
  localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   dvd;
  logic [W-1:0]   dvs;
  logic [W-1:0]   rem;
  logic [CW-1:0]  count;
  logic           neg_q;
  logic           neg_r;
  logic           dz;

  logic           latch_c;
  logic           step_c;
  logic           finish_c;
  logic           go_idle_c;

  // Operand magnitudes; a zero divisor forces unsigned treatment of both operands.
  logic           sgn_eff_c;
  logic           a_neg_c;
  logic           b_neg_c;
  logic [W-1:0]   a_mag_c;
  logic [W-1:0]   b_mag_c;
  logic           skip_c;

  always_comb begin
    sgn_eff_c = Sign & (in2 != '0);
    a_neg_c   = sgn_eff_c & in1[W-1];
    b_neg_c   = sgn_eff_c & in2[W-1];
    a_mag_c   = a_neg_c ? (~in1 + W'(1)) : in1;
    b_mag_c   = b_neg_c ? (~in2 + W'(1)) : in2;
  end

`ifdef ITER_DIV_EARLY_OUT_EN
  logic early;
  logic early_finish_c;
  assign skip_c = (in2 == '0) | (b_mag_c > a_mag_c);
`else
  assign skip_c = 1'b0;
`endif

  // One restoring step: shift next dividend bit into the partial remainder.
  logic [W:0]     trial_c;
  logic           ge_c;
  logic [W-1:0]   rem_step_c;
  logic [W-1:0]   dvd_step_c;

  always_comb begin
    trial_c    = {rem, dvd[W-1]};
    ge_c       = trial_c >= {1'b0, dvs};
    rem_step_c = ge_c ? W'(trial_c - {1'b0, dvs}) : trial_c[W-1:0];
    dvd_step_c = {dvd[W-2:0], ge_c};
  end

  logic [W-1:0]   q_fix_c;
  logic [W-1:0]   r_fix_c;

  always_comb begin
    q_fix_c = neg_q ? (~dvd + W'(1)) : dvd;
    r_fix_c = neg_r ? (~rem + W'(1)) : rem;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch_c   = 1'b0;
    step_c    = 1'b0;
    finish_c  = 1'b0;
    go_idle_c = 1'b0;
`ifdef ITER_DIV_EARLY_OUT_EN
    early_finish_c = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          latch_c   = 1'b1;
          state_nxt = skip_c ? DONE : CALC;
        end
      end
      CALC: begin
        step_c = 1'b1;
        if (count == LAST_ITER) state_nxt = FIX;
      end
      FIX: begin
        finish_c  = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
`ifdef ITER_DIV_EARLY_OUT_EN
        // Short path spends its first DONE cycle producing the result.
        if (early) begin
          early_finish_c = 1'b1;
        end else begin
          go_idle_c = 1'b1;
          state_nxt = IDLE;
        end
`else
        go_idle_c = 1'b1;
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      count     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dz        <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
`ifdef ITER_DIV_EARLY_OUT_EN
      early     <= 1'b0;
`endif
    end else begin
      if (latch_c) begin
        dvd      <= a_mag_c;
        dvs      <= b_mag_c;
        rem      <= '0;
        count    <= '0;
        neg_q    <= a_neg_c ^ b_neg_c;
        neg_r    <= a_neg_c;
        dz       <= (in2 == '0);
        div_zero <= 1'b0;
        busy     <= 1'b1;
`ifdef ITER_DIV_EARLY_OUT_EN
        early    <= skip_c;
`endif
      end
      if (step_c) begin
        rem   <= rem_step_c;
        dvd   <= dvd_step_c;
        count <= count + CW'(1);
      end
      if (finish_c) begin
        quotient  <= q_fix_c;
        remainder <= r_fix_c;
        div_zero  <= dz;
        done      <= 1'b1;
      end
`ifdef ITER_DIV_EARLY_OUT_EN
      // Quotient magnitude is all-ones (zero divisor) or zero; remainder is the dividend.
      if (early_finish_c) begin
        quotient  <= dz ? '1 : '0;
        remainder <= neg_r ? (~dvd + W'(1)) : dvd;
        div_zero  <= dz;
        done      <= 1'b1;
        early     <= 1'b0;
      end
`endif
      if (go_idle_c) begin
        done <= 1'b0;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: doc/iter_div.md
ITER_DIV -- requirements
Module: iter_div

Interface
REQ-001 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-004 SHALL have port in1  input  32  dividend.
REQ-005 SHALL have port in2  input  32  divisor.
REQ-006 SHALL have port Sign  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-007 SHALL have port quotient  output  32  registered quotient.
REQ-008 SHALL have port remainder  output  32  registered remainder.
REQ-009 SHALL have port busy  output  1  high while a division is in progress.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port div_zero  output  1  last completed division had in2 == 0.

Function
REQ-012 SHALL implement states IDLE, CALC, FIX and DONE only.
REQ-013 SHALL, in IDLE with start=1 at a rising edge, latch in1, in2 and Sign, clear div_zero, set busy, and enter CALC with iteration count 0.
REQ-014 SHALL ignore start in every state other than IDLE, and SHALL ignore in1, in2 and Sign after the latch edge.
REQ-015 SHALL, in signed mode, divide the operand magnitudes; an operand magnitude of 0x80000000 is the unsigned value 2^31.
REQ-016 SHALL perform radix-2 restoring division in CALC, one quotient bit per edge, MSB first, for exactly 32 edges.
REQ-017 SHALL move CALC->FIX after the 32nd iteration and apply sign correction in FIX.
REQ-018 SHALL negate the quotient when latched Sign=1 and the dividend and divisor signs differ.
REQ-019 SHALL negate the remainder when latched Sign=1 and the dividend is negative.
REQ-020 SHALL move FIX->DONE while writing quotient and remainder and setting done=1.
REQ-021 SHALL clear done and busy on the DONE->IDLE edge.
REQ-022 SHALL give done=1 exactly in the cycle after the 34th rising edge counted from the start-latch edge.
REQ-023 SHALL hold quotient, remainder and div_zero stable from DONE until the next start is latched.
REQ-024 SHALL, when in2 == 0, return quotient 0xFFFFFFFF and remainder equal to the original in1, set div_zero=1, and ignore Sign.
REQ-025 SHALL, for signed 0x80000000 / 0xFFFFFFFF, return quotient 0x80000000 and remainder 0 without any error flag.
REQ-026 SHALL keep busy=1 throughout CALC, FIX and DONE, and busy=0 in IDLE.
REQ-027 SHALL accept a start asserted in the cycle after done (back-to-back operation).

Reset
REQ-028 SHALL, on reset assertion, immediately and asynchronously enter IDLE.
REQ-029 SHALL, on reset assertion, drive quotient=0, remainder=0, busy=0, done=0 and div_zero=0.
REQ-030 SHALL, on reset during CALC or FIX, abort the operation with no done pulse.
REQ-031 SHALL ignore start on any edge where reset is high.

Configuration
REQ-032 SHALL support macro ITER_DIV_EARLY_OUT_EN.
REQ-033 SHALL, when ITER_DIV_EARLY_OUT_EN is defined, skip CALC and FIX for two cases:
  - in2 == 0;
  - divisor magnitude > dividend magnitude.
REQ-034 SHALL, on such a skip, go IDLE->DONE, giving done in the cycle after the 2nd edge from start-latch.
REQ-035 SHALL, on such a skip, produce results identical to the full algorithm, including sign rules and REQ-024.
REQ-036 SHALL, when ITER_DIV_EARLY_OUT_EN is undefined, take 34 edges for every operation, including in2 == 0.

Verification
REQ-037 SHALL cover: Sign=0, in1=100, in2=7, start pulse -> done at edge 34; quotient=14, remainder=2, div_zero=0.
REQ-038 SHALL cover: Sign=1, in1=0xFFFFFFF9 (-7), in2=2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
REQ-039 SHALL cover: in1=5, in2=0 -> quotient=0xFFFFFFFF, remainder=5, div_zero=1; done at edge 34 without the macro, edge 2 with it.
REQ-040 SHALL cover: Sign=1, in1=0x80000000, in2=0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-041 SHALL cover: start re-asserted with in1=9, in2=3 at edge 10 of an active 100/7 operation -> ignored; result stays 14/2.
REQ-042 SHALL cover: reset pulsed between edges 10 and 11 of an operation -> busy=0 and quotient=0 immediately, no done; a new 100/7 then completes normally.
